// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode, FSM state and iteration constants for the ALU execute stage.
package alu_exec_stage_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'b0000,
        OpSub   = 4'b0001,
        OpAnd   = 4'b0010,
        OpOr    = 4'b0011,
        OpXor   = 4'b0100,
        OpNor   = 4'b0101,
        OpSll   = 4'b0110,
        OpSrl   = 4'b0111,
        OpSra   = 4'b1000,
        OpSlt   = 4'b1001,
        OpMulu  = 4'b1010,
        OpDivu  = 4'b1011,
        OpPassb = 4'b1100
    } alu_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StIter = 1'b1
    } state_e;

    localparam int unsigned IterLast = 15;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per step.
// The low half of the accumulator starts as operand A and ends as product-low / quotient.
module mul_div_iter
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ITER_CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             step_en_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_step_o,
    output logic             is_div_o,
    output logic [WIDTH-1:0] next_lo_o,
    output logic [WIDTH-1:0] next_hi_o
);

    logic [WIDTH-1:0]      b_q, b_d;
    logic                  div_q, div_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d, acc_step;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]        hi_sum, rem, rem_diff;

    always_comb begin
        hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder after shifting in the next dividend bit.
        rem      = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem - {1'b0, b_q};
        acc_step = acc_q;
        if (div_q) begin
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {hi_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        b_d   = b_q;
        div_d = div_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_i) begin
            b_d   = b_i;
            div_d = is_div_i;
            acc_d = {{WIDTH{1'b0}}, a_i};
            cnt_d = '0;
        end else if (step_en_i) begin
            acc_d = acc_step;
            cnt_d = cnt_q + ITER_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            b_q   <= '0;
            div_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            b_q   <= b_d;
            div_q <= div_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_step_o = (cnt_q == ITER_CNT_W'(IterLast));
    assign is_div_o    = div_q;
    assign next_lo_o   = acc_step[WIDTH-1:0];
    assign next_hi_o   = acc_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU, iterative MULU/DIVU, registered results and flags,
// with a start/busy/done handshake toward the control FSM.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ITER_CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALU_1_IN,
    input  logic [WIDTH-1:0] ALU_2_IN,
    input  logic [3:0]       C_ALUOp,
    input  logic             C_ALUStart,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutHi,
    output logic             F_Zero,
    output logic             F_Neg,
    output logic             F_Carry,
    output logic             F_Ovf,
    output logic             F_DivZero,
    output logic             C_ALUBusy,
    output logic             C_ALUDone
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]      sc_lo;
    logic                  sc_carry, sc_ovf;
    logic [WIDTH:0]        sum, diff;
    logic [ITER_CNT_W-1:0] shamt;

    logic             load, step_en, commit;
    logic             iter_last, iter_is_div;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    logic [WIDTH-1:0] res_lo, res_hi;
    logic             res_carry, res_ovf, res_dz;

    logic [WIDTH-1:0] out_q, out_hi_q;
    logic             zero_q, neg_q, carry_q, ovf_q, dz_q, done_q;

    assign sum   = {1'b0, ALU_1_IN} + {1'b0, ALU_2_IN};
    assign diff  = {1'b0, ALU_1_IN} - {1'b0, ALU_2_IN};
    assign shamt = ALU_2_IN[ITER_CNT_W-1:0];

    always_comb begin
        sc_lo    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (C_ALUOp)
            OpAdd: begin
                sc_lo    = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (ALU_1_IN[WIDTH-1] == ALU_2_IN[WIDTH-1]) &&
                           (sum[WIDTH-1] != ALU_1_IN[WIDTH-1]);
            end
            OpSub: begin
                sc_lo    = diff[WIDTH-1:0];
                sc_carry = ~diff[WIDTH];
                sc_ovf   = (ALU_1_IN[WIDTH-1] != ALU_2_IN[WIDTH-1]) &&
                           (diff[WIDTH-1] != ALU_1_IN[WIDTH-1]);
            end
            OpAnd:   sc_lo = ALU_1_IN & ALU_2_IN;
            OpOr:    sc_lo = ALU_1_IN | ALU_2_IN;
            OpXor:   sc_lo = ALU_1_IN ^ ALU_2_IN;
            OpNor:   sc_lo = ~(ALU_1_IN | ALU_2_IN);
            OpSll:   sc_lo = ALU_1_IN << shamt;
            OpSrl:   sc_lo = ALU_1_IN >> shamt;
            OpSra:   sc_lo = $unsigned($signed(ALU_1_IN) >>> shamt);
            OpSlt:   sc_lo = {{(WIDTH-1){1'b0}}, $signed(ALU_1_IN) < $signed(ALU_2_IN)};
            OpPassb: sc_lo = ALU_2_IN;
            default: sc_lo = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step_en   = 1'b0;
        commit    = 1'b0;
        res_lo    = sc_lo;
        res_hi    = '0;
        res_carry = sc_carry;
        res_ovf   = sc_ovf;
        res_dz    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (C_ALUStart) begin
                    if (C_ALUOp == OpMulu || (C_ALUOp == OpDivu && ALU_2_IN != '0)) begin
                        load    = 1'b1;
                        state_d = StIter;
                    end else begin
                        commit = 1'b1;
                        // Zero divisor completes at once with all-ones quotient.
                        if (C_ALUOp == OpDivu) begin
                            res_lo = '1;
                            res_hi = ALU_1_IN;
                            res_dz = 1'b1;
                        end
                    end
                end
            end
            StIter: begin
                step_en   = 1'b1;
                res_lo    = iter_lo;
                res_hi    = iter_hi;
                res_carry = !iter_is_div && (iter_hi != '0);
                res_ovf   = 1'b0;
                if (iter_last) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    mul_div_iter #(
        .WIDTH      (WIDTH),
        .ITER_CNT_W (ITER_CNT_W)
    ) u_mul_div_iter (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (load),
        .step_en_i   (step_en),
        .is_div_i    (C_ALUOp == OpDivu),
        .a_i         (ALU_1_IN),
        .b_i         (ALU_2_IN),
        .last_step_o (iter_last),
        .is_div_o    (iter_is_div),
        .next_lo_o   (iter_lo),
        .next_hi_o   (iter_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            done_q   <= 1'b0;
            out_q    <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= commit;
            if (commit) begin
                out_q    <= res_lo;
                out_hi_q <= res_hi;
                zero_q   <= (res_lo == '0);
                neg_q    <= res_lo[WIDTH-1];
                carry_q  <= res_carry;
                ovf_q    <= res_ovf;
                dz_q     <= res_dz;
            end
        end
    end

    assign ALUOut    = out_q;
    assign ALUOutHi  = out_hi_q;
    assign F_Zero    = zero_q;
    assign F_Neg     = neg_q;
    assign F_Carry   = carry_q;
    assign F_Ovf     = ovf_q;
    assign F_DivZero = dz_q;
    assign C_ALUBusy = (state_q == StIter);
    assign C_ALUDone = done_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage fed directly by the ALU operand mux (ALU_1_IN / ALU_2_IN).
- Performs the selected 16-bit operation and registers the result (ALUOut) and status flags for the write-back and branch logic.
- Single-cycle ops take one clock. Unsigned multiply and divide are iterative: 16 cycles, with a start/busy/done handshake toward the control FSM.

Parameters:
- WIDTH, 16, datapath width. Only 16 is supported.
- ITER_CNT_W, 4, iteration counter width. Must satisfy 2^ITER_CNT_W == WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ALU_1_IN  input  16  operand A, from the operand mux.
- ALU_2_IN  input  16  operand B, from the operand mux.
- C_ALUOp  input  4  operation select.
- C_ALUStart  input  1  start strobe; sampled only when not busy.
- ALUOut  output  16  registered primary result (low product / quotient).
- ALUOutHi  output  16  registered high product / remainder.
- F_Zero  output  1  registered flag: ALUOut == 0.
- F_Neg  output  1  registered flag: ALUOut[15].
- F_Carry  output  1  registered carry / no-borrow / high-word-nonzero flag.
- F_Ovf  output  1  registered signed-overflow flag.
- F_DivZero  output  1  registered flag: last DIVU had a zero divisor.
- C_ALUBusy  output  1  high while an iterative op is in progress.
- C_ALUDone  output  1  one-cycle pulse when results and flags are valid.

Behaviour:
- Reset: synchronous, active-high.
  - All outputs go to 0; state goes to IDLE; counter goes to 0.
  - Reset mid-iteration aborts the op: no done pulse, results stay 0.
- Opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR, 0101 NOR
  - 0110 SLL, 0111 SRL, 1000 SRA: shift A by B[3:0]
  - 1001 SLT: signed, result 1 or 0
  - 1010 MULU (iterative), 1011 DIVU (iterative)
  - 1100 PASSB
  - 1101-1111: result 0, flags computed on that result, done after 1 cycle.
- States:
  - IDLE: C_ALUBusy=0.
  - ITER: C_ALUBusy=1.
- Single-cycle ops:
  - C_ALUStart high in IDLE at cycle N: ALUOut, ALUOutHi (=0) and flags registered at the N/N+1 edge.
  - C_ALUDone=1 during cycle N+1 only. State stays IDLE.
- Iterative ops:
  - Start in IDLE at cycle N latches A, B, op and clears the accumulator and counter; IDLE->ITER.
  - C_ALUBusy=1 during cycles N+1..N+16, one shift-add or restoring-subtract step per cycle.
  - The edge ending the step with counter==15 writes ALUOut, ALUOutHi and flags, pulses C_ALUDone in cycle N+17, and returns to IDLE.
- Flags:
  - Updated only on the edge that raises C_ALUDone; otherwise they hold.
  - F_Zero = (ALUOut==0); F_Neg = ALUOut[15].
  - ADD: F_Carry = carry out of bit 15; F_Ovf = signed overflow.
  - SUB: F_Carry = no-borrow (A>=B unsigned); F_Ovf = signed overflow.
  - MULU: F_Carry = (ALUOutHi != 0); F_Ovf = 0.
  - All other ops: F_Carry=0, F_Ovf=0.
  - F_DivZero is set only by DIVU with B==0 and cleared by every other completion.
- Divide by zero:
  - Detected at start. No iteration: ALUOut=16'hFFFF, ALUOutHi=A, F_DivZero=1.
  - Done after 1 cycle, same timing as a single-cycle op.
- Handshake rules:
  - C_ALUStart while busy is ignored; latched operands are unaffected by input changes during ITER.
  - Start is accepted in the same cycle C_ALUDone is high (back-to-back ops allowed).
- Arithmetic:
  - ALUOut and ALUOutHi are 16 bits; internal add/sub use a 17-bit sum for carry.
  - MULU computes the full 32-bit unsigned product: {ALUOutHi, ALUOut}.

Decomposition:
- Shared include alu_defs.vh holds:
  - the C_ALUOp opcode localparams (ADD..PASSB);
  - the state encodings IDLE=1'b0, ITER=1'b1;
  - the ITER_LAST constant (15).
- One sub-module, mul_div_iter:
  - holds the latched operands, 32-bit accumulator, counter and the per-step shift-add / restoring-divide datapath;
  - exposes step_en, load and a last-step indication.
- The top level keeps the single-cycle ALU, flag logic, FSM and output registers.

Test Plan:
- Reset, then ADD A=16'h7FFF, B=16'h0001 -> cycle N+1: ALUOut=16'h8000, F_Ovf=1, F_Neg=1, F_Carry=0, F_Zero=0, C_ALUDone pulse of 1 cycle.
- SUB A=16'h0005, B=16'h0005 -> ALUOut=0, F_Zero=1, F_Carry=1; then SLT A=16'hFFFF, B=16'h0001 -> ALUOut=1.
- MULU A=16'h1234, B=16'h0100 -> C_ALUBusy high cycles N+1..N+16; cycle N+17: ALUOut=16'h3400, ALUOutHi=16'h0012, F_Carry=1. A start pulse at N+5 with different operands is ignored.
- DIVU A=16'd1000, B=16'd7 -> done at N+17 with ALUOut=16'd142, ALUOutHi=16'd6. Then DIVU A=16'h00AB, B=0 -> done at N+1 with ALUOut=16'hFFFF, ALUOutHi=16'h00AB, F_DivZero=1.
- Back-to-back: start DIVU in the same cycle a MULU done pulse is high -> accepted, busy the next cycle, and the MULU result visible for exactly that one done cycle.
- Assert reset at N+8 of a MULU -> the next cycle has all outputs 0, C_ALUBusy=0, and no C_ALUDone pulse afterwards.
